// File: rtl/pc_sequencer.sv
// Fetch program-counter sequencer: sequential advance, branch/jump redirect,
// a circular return-address stack for call/return, and a sticky halt flag.
module pc_sequencer #(
    parameter int                     PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0]    PC_INIT   = '0,
    parameter logic [PC_WIDTH-1:0]    PC_INC    = PC_WIDTH'(4),
    parameter int                     RAS_DEPTH = 4,
    localparam int                    CNT_W     = $clog2(RAS_DEPTH + 1)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                adv,
    input  logic                halt,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic                call,
    input  logic                ret,
    output logic [PC_WIDTH-1:0] PC,
    output logic                halted,
    output logic [CNT_W-1:0]    ras_count,
    output logic                ras_underflow
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];

    logic [PC_WIDTH-1:0] pc_r;
    logic                halted_r;
    logic [PTR_W-1:0]    ptr_r;
    logic [CNT_W-1:0]    count_r;
    logic                underflow_r;

    logic                step_s;
    logic                empty_s;
    logic                pop_s;
    logic                push_s;
    logic [PC_WIDTH-1:0] seq_pc_s;
    logic [PC_WIDTH-1:0] top_s;
    logic [PC_WIDTH-1:0] next_pc_s;
    logic [PTR_W-1:0]    ptr_inc_s;
    logic [PTR_W-1:0]    ptr_dec_s;
    logic [PTR_W-1:0]    wr_idx_s;
    logic [PTR_W-1:0]    next_ptr_s;
    logic [CNT_W-1:0]    next_count_s;

    // ptr_r addresses the next free slot; the top of stack sits one below it.
    assign step_s    = adv & ~halt & ~halted_r;
    assign empty_s   = (count_r == CNT_W'(0));
    assign pop_s     = step_s & ret & ~empty_s;
    assign push_s    = step_s & call;
    assign seq_pc_s  = pc_r + PC_INC;
    assign ptr_inc_s = (ptr_r == PTR_LAST) ? PTR_W'(0) : ptr_r + PTR_W'(1);
    assign ptr_dec_s = (ptr_r == PTR_W'(0)) ? PTR_LAST : ptr_r - PTR_W'(1);
    assign top_s     = ras_mem[ptr_dec_s];

    // Next-PC selection and RAS pointer/count bookkeeping.
    always_comb begin
        next_pc_s    = pc_r;
        next_ptr_s   = ptr_r;
        next_count_s = count_r;
        wr_idx_s     = ptr_r;
        if (!step_s) begin
            next_pc_s = pc_r;
        end else if (pop_s && call) begin
            // Return and re-push into the same slot: depth is unchanged.
            next_pc_s = top_s;
            wr_idx_s  = ptr_dec_s;
        end else if (pop_s) begin
            next_pc_s    = top_s;
            next_ptr_s   = ptr_dec_s;
            next_count_s = count_r - CNT_W'(1);
        end else begin
            next_pc_s = redirect ? redirect_pc : seq_pc_s;
            if (call) begin
                next_ptr_s   = ptr_inc_s;
                next_count_s = (count_r == CNT_FULL) ? count_r : count_r + CNT_W'(1);
            end else begin
                next_ptr_s   = ptr_r;
                next_count_s = count_r;
            end
        end
    end

    // Architectural state registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_r        <= PC_INIT;
            halted_r    <= 1'b0;
            ptr_r       <= '0;
            count_r     <= '0;
            underflow_r <= 1'b0;
        end else begin
            pc_r        <= next_pc_s;
            halted_r    <= halted_r | halt;
            ptr_r       <= next_ptr_s;
            count_r     <= next_count_s;
            underflow_r <= step_s & ret & empty_s;
        end
    end

    // RAS storage; contents are meaningless until pushed, so no reset.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            ras_mem[wr_idx_s] <= seq_pc_s;
        end
    end

    assign PC            = pc_r;
    assign halted        = halted_r;
    assign ras_count     = count_r;
    assign ras_underflow = underflow_r;

endmodule
